// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP add/sub unit (start/done handshake) among NREQ requesters.
// Optional watchdog abort is built when FPU_ARB_WDOG_EN is defined.
module fpu_addsub_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*32-1:0] req_a,
   input  logic [NREQ*32-1:0] req_b,
   input  logic [NREQ-1:0]   req_sel,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [31:0]       rsp_result,
   output logic              rsp_err,
   output logic              fpu_start,
   output logic [31:0]       fpu_a,
   output logic [31:0]       fpu_b,
   output logic              fpu_sel,
   input  logic [31:0]       fpu_result,
   input  logic              fpu_done,
   input  logic              fpu_busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

   state_t          state_reg;
   logic [IW-1:0]   last_reg;
   logic [IW-1:0]   g_reg;
   logic [IW-1:0]   grant_idx;
   logic [NREQ-1:0] grant;
   logic            found;
   logic            handshake;
   logic [NREQ-1:0] rsp_valid_reg;
   logic [31:0]     rsp_result_reg;
   logic            fpu_start_reg;
   logic [31:0]     fpu_a_reg;
   logic [31:0]     fpu_b_reg;
   logic            fpu_sel_reg;
   logic [31:0]     a_arr [NREQ];
   logic [31:0]     b_arr [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
         assign a_arr[gi] = req_a[32*gi +: 32];
         assign b_arr[gi] = req_b[32*gi +: 32];
      end
   endgenerate

   // Search starts one past the last winner and wraps, so the last winner has lowest priority.
   always_comb begin
      logic [IW-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = IW'((int'(last_reg) + i) % NREQ);
         if (!found && req_valid[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            found      = 1'b1;
         end
      end
   end

   // A stale done in IDLE blocks grants until the unit is truly idle.
   assign req_ready = (state_reg == S_IDLE && !rst && !fpu_done) ? grant : '0;
   assign handshake = |(req_valid & req_ready);

`ifdef FPU_ARB_WDOG_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wdog_cnt_reg;
   logic          rsp_err_reg;
   assign rsp_err = rsp_err_reg;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         last_reg       <= IW'(NREQ - 1);
         g_reg          <= '0;
         rsp_valid_reg  <= '0;
         rsp_result_reg <= '0;
         fpu_start_reg  <= 1'b0;
         fpu_a_reg      <= '0;
         fpu_b_reg      <= '0;
         fpu_sel_reg    <= 1'b0;
`ifdef FPU_ARB_WDOG_EN
         wdog_cnt_reg   <= '0;
         rsp_err_reg    <= 1'b0;
`endif
      end else begin
         rsp_valid_reg <= '0;
`ifdef FPU_ARB_WDOG_EN
         rsp_err_reg   <= 1'b0;
`endif
         case (state_reg)
            S_IDLE: begin
               if (handshake) begin
                  fpu_a_reg   <= a_arr[grant_idx];
                  fpu_b_reg   <= b_arr[grant_idx];
                  fpu_sel_reg <= req_sel[grant_idx];
                  g_reg       <= grant_idx;
                  last_reg    <= grant_idx;
                  state_reg   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               fpu_start_reg <= 1'b1;
`ifdef FPU_ARB_WDOG_EN
               wdog_cnt_reg  <= '0;
`endif
               state_reg     <= S_WAIT;
            end
            S_WAIT: begin
               if (fpu_done) begin
                  rsp_result_reg <= fpu_result;
                  fpu_start_reg  <= 1'b0;
                  rsp_valid_reg  <= NREQ'(1) << g_reg;
                  state_reg      <= S_RESP;
               end
`ifdef FPU_ARB_WDOG_EN
               else if (wdog_cnt_reg == CW'(TIMEOUT - 1)) begin
                  rsp_result_reg <= 32'h7FC0_0000;
                  rsp_err_reg    <= 1'b1;
                  fpu_start_reg  <= 1'b0;
                  rsp_valid_reg  <= NREQ'(1) << g_reg;
                  state_reg      <= S_DRAIN;
               end else begin
                  wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
               end
`endif
            end
            S_RESP:  state_reg <= S_DRAIN;
            // Wait for done to fall so the next start is not absorbed by the unit's done-hold.
            S_DRAIN: if (!fpu_done) state_reg <= S_IDLE;
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid  = rsp_valid_reg;
   assign rsp_result = rsp_result_reg;
   assign fpu_start  = fpu_start_reg;
   assign fpu_a      = fpu_a_reg;
   assign fpu_b      = fpu_b_reg;
   assign fpu_sel    = fpu_sel_reg;

   a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
   a_idle_unit_free: assert property (@(posedge clk) disable iff (rst)
      (state_reg == S_IDLE) |-> !fpu_busy);

endmodule
